// File: rtl/weighted_centroid_pkg.sv
// Shared types and width helpers for the weighted-centroid engine.
// The derived constants describe the default build (N_PTS=3, DATA_W=17).
package weighted_centroid_pkg;

   function automatic int clog2(input int value);
      int r = 0;
      int v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   localparam int N_PTS_DEF  = 3;
   localparam int DATA_W_DEF = 17;
   localparam int LOG_N      = clog2(N_PTS_DEF);
   localparam int SUMW_W     = DATA_W_DEF + LOG_N;
   localparam int ACC_W      = 2 * DATA_W_DEF + LOG_N;

   typedef enum logic [2:0] {LOAD, DIV_X, DIV_Y, OUT_X, OUT_Y} state_e;

endpackage

// File: rtl/wc_seq_div.sv
// Restoring divider, one quotient bit per cycle, first bit resolved on the start edge.
// The caller guarantees the quotient fits in Q_W bits, so only the top R_W dividend bits seed the remainder.
module wc_seq_div
   import weighted_centroid_pkg::*;
#(
   parameter int DVD_W = ACC_W,
   parameter int Q_W   = DATA_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DVD_W-1:0]     dividend,
   input  logic [DVD_W-Q_W-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic [Q_W-1:0]       quotient,
   output logic                 div0
);
   localparam int R_W   = DVD_W - Q_W;
   localparam int CNT_W = clog2(Q_W);

   logic [R_W-1:0]   rem_q, rem_d, rem_src, dsr_q, dsr_d, dsr_src, diff;
   logic [Q_W-1:0]   low_q, low_d, quo_q, quo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             zero_q, zero_d, done_q, done_d, bit_src, fits;
   logic [R_W:0]     trial;

   // NOTE: every variable driven here gets a default before any branch, so no latch is inferred.
   always_comb begin
      rem_src = start ? dividend[DVD_W-1:Q_W] : rem_q;
      bit_src = start ? dividend[Q_W-1] : low_q[Q_W-1];
      dsr_src = start ? divisor : dsr_q;
      trial   = {rem_src, bit_src};
      fits    = trial >= {1'b0, dsr_src};
      diff    = trial[R_W-1:0] - dsr_src;

      rem_d  = rem_q;
      low_d  = low_q;
      quo_d  = quo_q;
      dsr_d  = dsr_q;
      zero_d = zero_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (start) begin
         rem_d  = fits ? diff : trial[R_W-1:0];
         low_d  = {dividend[Q_W-2:0], 1'b0};
         quo_d  = {{(Q_W-1){1'b0}}, fits};
         dsr_d  = divisor;
         zero_d = (divisor == '0);
         cnt_d  = CNT_W'(Q_W - 1);
      end else if (busy) begin
         rem_d  = fits ? diff : trial[R_W-1:0];
         low_d  = {low_q[Q_W-2:0], 1'b0};
         quo_d  = {quo_q[Q_W-2:0], fits};
         cnt_d  = cnt_q - CNT_W'(1);
         done_d = (cnt_q == CNT_W'(1));
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         low_q  <= '0;
         quo_q  <= '0;
         dsr_q  <= '0;
         zero_q <= 1'b0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         low_q  <= low_d;
         quo_q  <= quo_d;
         dsr_q  <= dsr_d;
         zero_q <= zero_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign busy     = (cnt_q != '0);
   assign done     = done_q;
   assign quotient = zero_q ? '0 : quo_q;
   assign div0     = zero_q;

endmodule

// File: rtl/weighted_centroid.sv
// Streaming weighted centroid: N points then N weights in, floor(sum(w*x)/sum(w)) and
// floor(sum(w*y)/sum(w)) out as two beats, with one divider shared between the axes.
module weighted_centroid
   import weighted_centroid_pkg::*;
#(
   parameter int N_PTS  = N_PTS_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [DATA_W-1:0] IN_DATA,
   input  logic              IN_VALID,
   output logic              IN_READY,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              OUT_VALID,
   output logic              OUT_DIV0
);
   localparam int LN    = clog2(N_PTS);
   localparam int SW_W  = DATA_W + LN;
   localparam int AW    = 2 * DATA_W + LN;
   localparam int CNT_W = clog2(3 * N_PTS);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(3 * N_PTS - 1);
   localparam logic [CNT_W-1:0] FIRST_WT  = CNT_W'(2 * N_PTS);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   xs_q [N_PTS];
   logic [DATA_W-1:0]   ys_q [N_PTS];
   logic [AW-1:0]       acc_x_q, acc_x_d, acc_y_q, acc_y_d, div_dvd;
   logic [SW_W-1:0]     sum_w_q, sum_w_d, div_dsr;
   logic [DATA_W-1:0]   quot_x_q, div_quot, out_data_q, out_data_d;
   logic                ready_q, ready_d, out_valid_q, out_valid_d, out_div0_q, out_div0_d;
   logic                accept, last_accept, is_weight;
   logic                div_start, div_busy, div_done, div_zero;
   logic [LN-1:0]       pt_idx, w_idx;
   logic [2*DATA_W-1:0] prod_x, prod_y;

   always_comb begin
      accept      = IN_VALID && ready_q;
      last_accept = accept && (cnt_q == LAST_WORD);
      is_weight   = (cnt_q >= FIRST_WT);
      pt_idx      = LN'(cnt_q >> 1);
      w_idx       = LN'(cnt_q - FIRST_WT);
      prod_x      = {{DATA_W{1'b0}}, IN_DATA} * {{DATA_W{1'b0}}, xs_q[w_idx]};
      prod_y      = {{DATA_W{1'b0}}, IN_DATA} * {{DATA_W{1'b0}}, ys_q[w_idx]};

      cnt_d   = cnt_q;
      acc_x_d = acc_x_q;
      acc_y_d = acc_y_q;
      sum_w_d = sum_w_q;
      if (accept) begin
         cnt_d = last_accept ? '0 : cnt_q + CNT_W'(1);
         if (cnt_q == '0) begin
            acc_x_d = '0;
            acc_y_d = '0;
            sum_w_d = '0;
         end else if (is_weight) begin
            acc_x_d = acc_x_q + AW'(prod_x);
            acc_y_d = acc_y_q + AW'(prod_y);
            sum_w_d = sum_w_q + SW_W'(IN_DATA);
         end
      end
   end

   // The x division starts on the last-weight edge, so it reads the accumulators' next values.
   always_comb begin
      div_start = last_accept || ((state_q == DIV_X) && div_done && !div_busy);
      div_dvd   = (state_q == LOAD) ? acc_x_d : acc_y_q;
      div_dsr   = (state_q == LOAD) ? sum_w_d : sum_w_q;

      state_d = state_q;
      case (state_q)
         LOAD:    if (last_accept) state_d = DIV_X;
         DIV_X:   if (div_done) state_d = DIV_Y;
         DIV_Y:   if (div_done) state_d = OUT_X;
         OUT_X:   state_d = OUT_Y;
         OUT_Y:   state_d = LOAD;
         default: state_d = LOAD;
      endcase

      // Ready reopens one cycle after re-entering LOAD, keeping it low during the y beat.
      ready_d     = (state_d == LOAD) && (state_q == LOAD);
      out_valid_d = (state_q == OUT_X) || (state_q == OUT_Y);
      out_data_d  = '0;
      out_div0_d  = 1'b0;
      if (state_q == OUT_X) begin
         out_data_d = quot_x_q;
         out_div0_d = div_zero;
      end else if (state_q == OUT_Y) begin
         out_data_d = div_quot;
         out_div0_d = div_zero;
      end
   end

   wc_seq_div #(.DVD_W(AW), .Q_W(DATA_W)) u_div (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .start    (div_start),
      .dividend (div_dvd),
      .divisor  (div_dsr),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quot),
      .div0     (div_zero)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= LOAD;
         cnt_q       <= '0;
         acc_x_q     <= '0;
         acc_y_q     <= '0;
         sum_w_q     <= '0;
         quot_x_q    <= '0;
         ready_q     <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_div0_q  <= 1'b0;
         // NOTE: coordinate storage is only a few registers, so it is reset with everything else.
         for (int i = 0; i < N_PTS; i++) begin
            xs_q[i] <= '0;
            ys_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_x_q     <= acc_x_d;
         acc_y_q     <= acc_y_d;
         sum_w_q     <= sum_w_d;
         ready_q     <= ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_div0_q  <= out_div0_d;
         if ((state_q == DIV_X) && div_done) quot_x_q <= div_quot;
         if (accept && !is_weight) begin
            if (cnt_q[0]) ys_q[pt_idx] <= IN_DATA;
            else          xs_q[pt_idx] <= IN_DATA;
         end
      end
   end

   assign IN_READY  = ready_q;
   assign OUT_DATA  = out_data_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_DIV0  = out_div0_q;

endmodule

// File: tb/tb_weighted_centroid.sv
// Self-checking bench: directed and random frames on a 3-point and a 4-point instance,
// compared with a plain-arithmetic centroid model, including latency, gaps, busy input and resets.
module tb_weighted_centroid;
   localparam int DW = 17;
   localparam int LAT_X = 2 * DW + 1;

   typedef struct {
      longint data;
      bit     div0;
      int     cyc;
   } beat_t;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic [DW-1:0] in_data3, out_data3, in_data4, out_data4;
   logic          in_valid3, in_ready3, out_valid3, out_div03;
   logic          in_valid4, in_ready4, out_valid4, out_div04;

   int    cyc = 0;
   int    total = 0;
   int    bad = 0;
   int    idle_bad = 0;
   int    acc_t[$];
   beat_t bq3[$];
   beat_t bq4[$];

   weighted_centroid #(.N_PTS(3), .DATA_W(DW)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .IN_DATA(in_data3), .IN_VALID(in_valid3),
      .IN_READY(in_ready3), .OUT_DATA(out_data3), .OUT_VALID(out_valid3), .OUT_DIV0(out_div03));

   weighted_centroid #(.N_PTS(4), .DATA_W(DW)) dut4 (
      .CLK(CLK), .RESET_N(RESET_N), .IN_DATA(in_data4), .IN_VALID(in_valid4),
      .IN_READY(in_ready4), .OUT_DATA(out_data4), .OUT_VALID(out_valid4), .OUT_DIV0(out_div04));

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (out_valid3) bq3.push_back('{longint'(out_data3), out_div03, cyc});
      if (out_valid4) bq4.push_back('{longint'(out_data4), out_div04, cyc});
      if ((!out_valid3 && (out_data3 !== '0 || out_div03 !== 1'b0)) ||
          (!out_valid4 && (out_data4 !== '0 || out_div04 !== 1'b0)))
         idle_bad <= idle_bad + 1;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic void ref_centroid(input int unsigned w[$], input int n,
                                        output longint ex, output longint ey, output bit ez);
      longint unsigned sx = 0, sy = 0, sw = 0;
      for (int i = 0; i < n; i++) begin
         longint unsigned wi = w[2*n + i];
         sw += wi;
         sx += wi * w[2*i];
         sy += wi * w[2*i + 1];
      end
      ez = (sw == 0);
      ex = ez ? 0 : longint'(sx / sw);
      ey = ez ? 0 : longint'(sy / sw);
   endfunction

   // Presents words in order, holding each until accepted; gap is the percent chance of an idle cycle.
   task automatic send_words(input int sel, input int unsigned w[$], input int gap);
      int i = 0;
      int guard = 0;
      acc_t.delete();
      while (i < w.size() && guard < 5000) begin
         bit go;
         bit rdy;
         go  = (gap == 0) || ($urandom_range(99) >= gap);
         rdy = sel ? in_ready4 : in_ready3;
         if (sel) begin
            in_valid4 = go;
            in_data4  = go ? DW'(w[i]) : DW'($urandom);
         end else begin
            in_valid3 = go;
            in_data3  = go ? DW'(w[i]) : DW'($urandom);
         end
         step();
         if (go && rdy) begin
            acc_t.push_back(cyc);
            i++;
         end
         guard++;
      end
      in_valid3 = 1'b0;
      in_valid4 = 1'b0;
      check("send.accepted", i, w.size());
   endtask

   task automatic check_frame(input string tag, input int sel, input int unsigned w[$], input int t_last);
      int     n = sel ? 4 : 3;
      int     waited = 0;
      longint ex, ey;
      bit     ez;
      beat_t  b0, b1;
      ref_centroid(w, n, ex, ey, ez);
      while ((sel ? bq4.size() : bq3.size()) < 2 && waited < 300) begin
         step();
         waited++;
      end
      check({tag, ".beats"}, longint'((sel ? bq4.size() : bq3.size()) >= 2), 1);
      if ((sel ? bq4.size() : bq3.size()) >= 2) begin
         if (sel) begin
            b0 = bq4.pop_front();
            b1 = bq4.pop_front();
         end else begin
            b0 = bq3.pop_front();
            b1 = bq3.pop_front();
         end
         check({tag, ".x"}, b0.data, ex);
         check({tag, ".y"}, b1.data, ey);
         check({tag, ".div0_x"}, b0.div0, ez);
         check({tag, ".div0_y"}, b1.div0, ez);
         check({tag, ".lat_x"}, b0.cyc - t_last, LAT_X);
         check({tag, ".lat_y"}, b1.cyc - t_last, LAT_X + 1);
      end
   endtask

   function automatic void rand_frame(input int n, output int unsigned w[$]);
      w.delete();
      for (int i = 0; i < 3 * n; i++) w.push_back($urandom_range(0, (1 << DW) - 1));
   endfunction

   initial begin
      int unsigned w[$];
      int unsigned w2[$];
      int          t1, t2, t_gap;

      RESET_N   = 1'b0;
      in_valid3 = 1'b0;
      in_data3  = '0;
      in_valid4 = 1'b0;
      in_data4  = '0;
      repeat (3) @(posedge CLK);
      #1;
      RESET_N = 1'b1;

      check("reset.ready", in_ready3, 1);
      check("reset.valid", out_valid3, 0);
      check("reset.data", out_data3, 0);
      check("reset.div0", out_div03, 0);
      check("reset.ready4", in_ready4, 1);

      w = '{0, 0, 4, 0, 0, 3, 5, 3, 4};
      send_words(0, w, 0);
      check_frame("incenter", 0, w, acc_t[$]);

      w = '{0, 0, 1, 0, 0, 1, 1, 1, 1};
      send_words(0, w, 40);
      check_frame("trunc_gaps", 0, w, acc_t[$]);

      w.delete();
      repeat (9) w.push_back(131071);
      send_words(0, w, 0);
      check_frame("extremes", 0, w, acc_t[$]);

      w = '{7, 9, 3, 5, 1, 2, 0, 0, 0};
      send_words(0, w, 0);
      check_frame("div0", 0, w, acc_t[$]);

      for (int k = 0; k < 6; k++) begin
         rand_frame(3, w);
         if (k == 0) begin
            w[6] = $urandom_range(0, 3);
            w[7] = 0;
            w[8] = $urandom_range(1, 3);
         end
         send_words(0, w, 30);
         check_frame($sformatf("random%0d", k), 0, w, acc_t[$]);
      end

      // Words offered while dividing must be dropped without disturbing this or the next frame.
      rand_frame(3, w);
      send_words(0, w, 0);
      t1 = acc_t[$];
      repeat (6) begin
         in_valid3 = 1'b1;
         in_data3  = DW'($urandom);
         step();
      end
      in_valid3 = 1'b0;
      check_frame("busy_pulse", 0, w, t1);
      rand_frame(3, w);
      send_words(0, w, 0);
      check_frame("after_busy", 0, w, acc_t[$]);

      rand_frame(3, w);
      send_words(0, w[0:4], 0);
      #2 RESET_N = 1'b0;
      #2;
      check("rst_mid.ready", in_ready3, 1);
      check("rst_mid.valid", out_valid3, 0);
      check("rst_mid.data", out_data3, 0);
      check("rst_mid.div0", out_div03, 0);
      step();
      RESET_N = 1'b1;
      rand_frame(3, w);
      send_words(0, w, 20);
      check_frame("after_rst_frame", 0, w, acc_t[$]);

      rand_frame(3, w);
      send_words(0, w, 0);
      repeat (10) step();
      RESET_N = 1'b0;
      #2;
      check("rst_div.ready", in_ready3, 1);
      check("rst_div.valid", out_valid3, 0);
      step();
      RESET_N = 1'b1;
      repeat (45) step();
      check("rst_div.no_beats", bq3.size(), 0);
      rand_frame(3, w);
      send_words(0, w, 0);
      check_frame("after_rst_div", 0, w, acc_t[$]);

      rand_frame(3, w);
      rand_frame(3, w2);
      send_words(0, {w, w2}, 0);
      t1    = acc_t[8];
      t2    = acc_t[17];
      t_gap = acc_t[9] - acc_t[8];
      check("b2b3.restart", t_gap, LAT_X + 3);
      check_frame("b2b3.f0", 0, w, t1);
      check_frame("b2b3.f1", 0, w2, t2);

      w = '{0, 0, 10, 0, 10, 10, 0, 10, 1, 1, 1, 1};
      rand_frame(4, w2);
      send_words(1, {w, w2}, 0);
      t1    = acc_t[11];
      t2    = acc_t[23];
      t_gap = acc_t[12] - acc_t[11];
      check("n4.restart", t_gap, LAT_X + 3);
      check_frame("n4.square", 1, w, t1);
      check_frame("n4.random", 1, w2, t2);

      repeat (5) step();
      check("idle_outputs_zero", idle_bad, 0);
      check("no_extra_beats", bq3.size() + bq4.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
